ft2232_fifo_ctrl: RTL

FPGA-side master for the FT2232H synchronous 245 FIFO interface, clocked by the 60 MHz clock the FT2232 drives out. It drives `fifo_oe_n`, `fifo_rd_n`, `fifo_wr_n` and `fifo_siwu`, samples `fifo_rxf_n` and `fifo_txe_n`, and owns the tristate direction of the 8-bit data bus. It converts host→FPGA bytes into a valid/ready RX stream and an FPGA→host valid/ready TX stream into bus writes. It sits between the top-level FT2232 pins and the test/command logic that exchanges CMD bytes with the host.

---
 rtl/ft2232_fifo_ctrl.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ft2232_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ft2232_fifo_ctrl
//
// FPGA-side master for the FT2232H synchronous 245 FIFO interface. Runs on
// the 60 MHz clock the FT2232 drives out. Host->FPGA bytes are read off the
// shared bus into a small RX FIFO and presented as a valid/ready stream;
// an FPGA->host valid/ready stream is written out through a 1-entry holding
// register. The single bus is time-shared between the two directions by a
// small FSM (IDLE, RD_OE, RD, WR, TURN) with burst-limited alternation.
//
// Optional feature: define FT2232_SIWU_EN to build the send-immediate logic.
// A one-cycle low pulse on fifo_siwu_o is issued SIWU_IDLE quiet IDLE cycles
// after a write burst. Without the macro fifo_siwu_o is tied high.
//
// Parameters
//   RX_DEPTH   RX FIFO entries (power of two, >= 4)
//   BURST_MAX  max consecutive RD/WR cycles while the other side waits (1..255)
//   SIWU_IDLE  quiet IDLE cycles before the SIWU pulse
//
// Ports
//   fifo_clk_i       FT2232 clock, the only clock
//   reset_n_i        synchronous active-low reset
//   fifo_rxf_n_i     low: FT2232 holds host data
//   fifo_txe_n_i     low: FT2232 can accept data
//   fifo_oe_n_o      low: FT2232 drives the bus
//   fifo_rd_n_o      read strobe (active low)
//   fifo_wr_n_o      write strobe (active low)
//   fifo_siwu_o      send-immediate / wake-up (active low)
//   fifo_data_io     8-bit bidirectional bus, driven by us only in WR
//   rx_data_o/rx_valid_o/rx_ready_i   received byte stream
//   tx_data_i/tx_valid_i/tx_ready_o   byte stream to send
// ---------------------------------------------------------------------------
module ft2232_fifo_ctrl #(
    parameter int RX_DEPTH  = 4,
    parameter int BURST_MAX = 64,
    parameter int SIWU_IDLE = 8
) (
    input  logic       fifo_clk_i,
    input  logic       reset_n_i,
    input  logic       fifo_rxf_n_i,
    input  logic       fifo_txe_n_i,
    output logic       fifo_oe_n_o,
    output logic       fifo_rd_n_o,
    output logic       fifo_wr_n_o,
    output logic       fifo_siwu_o,
    inout  wire  [7:0] fifo_data_io,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    // Elaboration-time guard on the parameter ranges the logic relies on.
    if (RX_DEPTH < 4 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 ||
        BURST_MAX < 1 || BURST_MAX > 255 || SIWU_IDLE < 1) begin : g_param_err
        $error("ft2232_fifo_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_OE = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        TURN  = 3'd4
    } state_t;

    state_t      state;
    logic        drive_q;      // FPGA owns the bus (set exactly while in WR)
    logic        last_wr;      // last burst direction was write
    logic [7:0]  burst_cnt;

    // ------------------------------------------------------------------
    // RX path: bus byte -> capture register -> FIFO
    // The capture register keeps the pad sample one flop from the bus; the
    // byte it holds is counted as "in flight" when judging free space.
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [RX_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          cap_vld;
    logic [7:0]    cap_data;
    logic          rx_push_bus;
    logic          rx_pop;
    logic          rx_room;

    assign rx_push_bus = !fifo_rd_n_o && !fifo_rxf_n_i;
    assign rx_valid_o  = (rx_cnt != '0);
    assign rx_data_o   = rx_mem[rx_rp];
    assign rx_pop      = rx_valid_o && rx_ready_i;

    // At least two free entries before this edge's push: one for the push
    // landing now and one for the push the next RD cycle would make, since
    // rd_n can only rise with a registered update.
    assign rx_room = (int'(rx_cnt) + int'(cap_vld)) <= (RX_DEPTH - 2);

    always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
            cap_vld <= 1'b0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            rx_cnt  <= '0;
        end else begin
            cap_vld <= rx_push_bus;
            if (cap_vld)
                rx_wp <= rx_wp + AW'(1);
            if (rx_pop)
                rx_rp <= rx_rp + AW'(1);
            rx_cnt <= rx_cnt + CW'(cap_vld) - CW'(rx_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge fifo_clk_i) begin
        if (rx_push_bus)
            cap_data <= fifo_data_io;
        if (cap_vld)
            rx_mem[rx_wp] <= cap_data;
    end

    // ------------------------------------------------------------------
    // TX path: 1-entry holding register feeding the bus
    // ------------------------------------------------------------------
    logic [7:0] tx_hold;
    logic       hold_full;
    logic       hold_full_nxt;
    logic       wr_accept;
    logic       tx_load;

    // The FT2232 takes the byte on an edge where our registered strobe is low
    // and it still reports space; otherwise the byte stays put for a retry.
    assign wr_accept     = !fifo_wr_n_o && !fifo_txe_n_i;
    assign tx_ready_o    = reset_n_i && (!hold_full || wr_accept);
    assign tx_load       = tx_valid_i && tx_ready_o;
    assign hold_full_nxt = tx_load ? 1'b1 : (wr_accept ? 1'b0 : hold_full);

    always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
            hold_full <= 1'b0;
            tx_hold   <= 8'h00;
        end else begin
            hold_full <= hold_full_nxt;
            if (tx_load)
                tx_hold <= tx_data_i;
        end
    end

    assign fifo_data_io = drive_q ? tx_hold : 8'bz;

    // ------------------------------------------------------------------
    // Arbitration and burst control
    // ------------------------------------------------------------------
    logic rd_pend, wr_pend, burst_hit, rd_exit, wr_exit;

    assign rd_pend   = !fifo_rxf_n_i && rx_room;
    assign wr_pend   = !fifo_txe_n_i && hold_full;
    // True on the edge that closes the BURST_MAX-th cycle of the burst.
    assign burst_hit = ({1'b0, burst_cnt} + 9'd1) >= 9'(BURST_MAX);
    assign rd_exit   = fifo_rxf_n_i || !rx_room || (burst_hit && wr_pend);
    assign wr_exit   = !hold_full_nxt || fifo_txe_n_i || (burst_hit && rd_pend);

    always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            fifo_oe_n_o <= 1'b1;
            fifo_rd_n_o <= 1'b1;
            fifo_wr_n_o <= 1'b1;
            drive_q     <= 1'b0;
            burst_cnt   <= 8'd0;
            last_wr     <= 1'b1;   // first contested arbitration goes to read
        end else begin
            case (state)
                IDLE: begin
                    // Alternate when both sides want the bus.
                    if (rd_pend && (!wr_pend || last_wr)) begin
                        state       <= RD_OE;
                        fifo_oe_n_o <= 1'b0;
                        last_wr     <= 1'b0;
                    end else if (wr_pend) begin
                        state       <= WR;
                        fifo_wr_n_o <= 1'b0;
                        drive_q     <= 1'b1;
                        burst_cnt   <= 8'd0;
                        last_wr     <= 1'b1;
                    end
                end
                RD_OE: begin
                    state       <= RD;
                    fifo_rd_n_o <= 1'b0;
                    burst_cnt   <= 8'd0;
                end
                RD: begin
                    if (rd_exit) begin
                        state       <= TURN;
                        fifo_oe_n_o <= 1'b1;
                        fifo_rd_n_o <= 1'b1;
                    end else if (burst_cnt != 8'hFF) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                WR: begin
                    if (wr_exit) begin
                        state       <= TURN;
                        fifo_wr_n_o <= 1'b1;
                        drive_q     <= 1'b0;
                    end else if (burst_cnt != 8'hFF) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    fifo_oe_n_o <= 1'b1;
                    fifo_rd_n_o <= 1'b1;
                    fifo_wr_n_o <= 1'b1;
                    drive_q     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Send-immediate / wake-up
    // ------------------------------------------------------------------
`ifdef FT2232_SIWU_EN
    localparam int IW = $clog2(SIWU_IDLE + 1);

    logic          siwu_armed;
    logic [IW-1:0] idle_cnt;
    logic          idle_quiet;

    // Quiet means parked in IDLE with nothing held and nothing offered.
    assign idle_quiet = (state == IDLE) && !hold_full && !tx_valid_i;

    always_ff @(posedge fifo_clk_i) begin
        if (!reset_n_i) begin
            fifo_siwu_o <= 1'b1;
            siwu_armed  <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            fifo_siwu_o <= 1'b1;
            if (wr_accept)
                siwu_armed <= 1'b1;
            if (idle_quiet) begin
                // Fires on the edge closing the SIWU_IDLE-th quiet cycle, so
                // the pulse occupies the following cycle; once per burst.
                if (siwu_armed && idle_cnt == IW'(SIWU_IDLE - 1)) begin
                    fifo_siwu_o <= 1'b0;
                    siwu_armed  <= 1'b0;
                end
                if (idle_cnt != IW'(SIWU_IDLE))
                    idle_cnt <= idle_cnt + IW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end
`else
    assign fifo_siwu_o = 1'b1;
`endif

endmodule
